frv_dmem_arbiter: RTL and testbench

Shares the single core data-memory port between two requesters. Port 0 is the memory-stage LSU; port 1 is a secondary master such as a debug or uncore DMA engine. Arbitration is fixed-priority in favour of port 0, with a starvation guard for port 1. Request-phase ownership is locked until grant. A small in-order owner FIFO routes each response back to the requester that issued the transaction. The block sits between the pipeline memory stage and the external dmem bus.

---
 rtl/frv_dmem_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_frv_dmem_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frv_dmem_arbiter.sv
// frv_dmem_arbiter: shares the core data-memory port between two requesters.
// Port 0 (LSU) has fixed priority; port 1 (debug/DMA) gets a starvation guard.
// Ports:
//   g_clk, g_resetn           clock, async active-low reset
//   rN_req/wen/strb/wdata/addr requester N request phase (N=0,1)
//   rN_gnt                     requester N request accepted
//   rN_recv/error/rdata, rN_ack requester N response phase
//   dmem_*                     shared dmem bus (request and response phases)
//   arb_outstanding            owner FIFO occupancy
//   arb_spurious               sticky: response seen with no owner
module frv_dmem_arbiter #(
    parameter int MAX_OUT    = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic                     g_clk,
    input  logic                     g_resetn,

    input  logic                     r0_req,
    input  logic                     r0_wen,
    input  logic [3:0]               r0_strb,
    input  logic [31:0]              r0_wdata,
    input  logic [31:0]              r0_addr,
    output logic                     r0_gnt,
    output logic                     r0_recv,
    input  logic                     r0_ack,
    output logic                     r0_error,
    output logic [31:0]              r0_rdata,

    input  logic                     r1_req,
    input  logic                     r1_wen,
    input  logic [3:0]               r1_strb,
    input  logic [31:0]              r1_wdata,
    input  logic [31:0]              r1_addr,
    output logic                     r1_gnt,
    output logic                     r1_recv,
    input  logic                     r1_ack,
    output logic                     r1_error,
    output logic [31:0]              r1_rdata,

    output logic                     dmem_req,
    output logic                     dmem_wen,
    output logic [3:0]               dmem_strb,
    output logic [31:0]              dmem_wdata,
    output logic [31:0]              dmem_addr,
    input  logic                     dmem_gnt,
    input  logic                     dmem_recv,
    output logic                     dmem_ack,
    input  logic                     dmem_error,
    input  logic [31:0]              dmem_rdata,

    output logic [$clog2(MAX_OUT):0] arb_outstanding,
    output logic                     arb_spurious
);

    localparam int CW = $clog2(MAX_OUT) + 1;
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic [CW-1:0]      count;
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [MAX_OUT-1:0] owner;
    logic               lock_v;
    logic               lock_id;
    logic [3:0]         starve;

    logic full;
    logic empty;
    logic sel_v;
    logic sel_id;
    logic head;
    logic push;
    logic pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(MAX_OUT - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign full  = (count == CW'(MAX_OUT));
    assign empty = (count == '0);
    assign head  = owner[rd_ptr];

    // A held lock outranks the starve override so a stalled
    // request is never replaced mid-handshake.
    always_comb begin
        sel_v  = 1'b0;
        sel_id = 1'b0;
        if (!full) begin
            if (lock_v) begin
                sel_v  = 1'b1;
                sel_id = lock_id;
            end else if (r1_req && starve == 4'(STARVE_LIM)) begin
                sel_v  = 1'b1;
                sel_id = 1'b1;
            end else if (r0_req) begin
                sel_v  = 1'b1;
                sel_id = 1'b0;
            end else if (r1_req) begin
                sel_v  = 1'b1;
                sel_id = 1'b1;
            end
        end
    end

    always_comb begin
        dmem_req   = 1'b0;
        dmem_wen   = 1'b0;
        dmem_strb  = '0;
        dmem_wdata = '0;
        dmem_addr  = '0;
        if (sel_v) begin
            if (sel_id) begin
                dmem_req   = r1_req;
                dmem_wen   = r1_wen;
                dmem_strb  = r1_strb;
                dmem_wdata = r1_wdata;
                dmem_addr  = r1_addr;
            end else begin
                dmem_req   = r0_req;
                dmem_wen   = r0_wen;
                dmem_strb  = r0_strb;
                dmem_wdata = r0_wdata;
                dmem_addr  = r0_addr;
            end
        end
    end

    assign r0_gnt = dmem_gnt & dmem_req & ~sel_id;
    assign r1_gnt = dmem_gnt & dmem_req & sel_id;
    assign push   = dmem_req & dmem_gnt;

    // With no owner recorded the response is drained and dropped.
    always_comb begin
        r0_recv  = 1'b0;
        r1_recv  = 1'b0;
        r0_error = 1'b0;
        r1_error = 1'b0;
        dmem_ack = dmem_recv;
        if (!empty) begin
            if (head) begin
                r1_recv  = dmem_recv;
                r1_error = dmem_error;
                dmem_ack = r1_ack;
            end else begin
                r0_recv  = dmem_recv;
                r0_error = dmem_error;
                dmem_ack = r0_ack;
            end
        end
    end

    assign pop      = dmem_recv & dmem_ack & ~empty;
    assign r0_rdata = dmem_rdata;
    assign r1_rdata = dmem_rdata;

    assign arb_outstanding = count;

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            count   <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            owner   <= '0;
        end else begin
            if (push) begin
                owner[wr_ptr] <= sel_id;
                wr_ptr        <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // Lock follows the bus: any cycle not ending in a stalled request
    // releases it, including an owner dropping req.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            lock_v  <= 1'b0;
            lock_id <= 1'b0;
        end else if (dmem_req && !dmem_gnt) begin
            lock_v  <= 1'b1;
            lock_id <= sel_id;
        end else begin
            lock_v  <= 1'b0;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            starve <= '0;
        end else if (r1_gnt) begin
            starve <= '0;
        end else if (r1_req && starve != 4'(STARVE_LIM)) begin
            starve <= starve + 4'd1;
        end
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            arb_spurious <= 1'b0;
        end else if (dmem_recv && empty) begin
            arb_spurious <= 1'b1;
        end
    end

endmodule

// File: tb/tb_frv_dmem_arbiter.sv
// tb_frv_dmem_arbiter: directed scenarios then randomized traffic,
// checked against a queue-based reference model of the arbiter.
module tb_frv_dmem_arbiter;

    localparam int MAX_OUT    = 2;
    localparam int STARVE_LIM = 4;
    localparam int CW         = $clog2(MAX_OUT) + 1;

    logic          g_clk = 1'b0;
    logic          g_resetn;
    logic          r0_req, r0_wen, r0_ack, r0_gnt, r0_recv, r0_error;
    logic [3:0]    r0_strb;
    logic [31:0]   r0_wdata, r0_addr, r0_rdata;
    logic          r1_req, r1_wen, r1_ack, r1_gnt, r1_recv, r1_error;
    logic [3:0]    r1_strb;
    logic [31:0]   r1_wdata, r1_addr, r1_rdata;
    logic          dmem_req, dmem_wen, dmem_gnt, dmem_recv, dmem_ack;
    logic          dmem_error;
    logic [3:0]    dmem_strb;
    logic [31:0]   dmem_wdata, dmem_addr, dmem_rdata;
    logic [CW-1:0] arb_outstanding;
    logic          arb_spurious;

    frv_dmem_arbiter #(
        .MAX_OUT    (MAX_OUT),
        .STARVE_LIM (STARVE_LIM)
    ) dut (
        .g_clk           (g_clk),
        .g_resetn        (g_resetn),
        .r0_req          (r0_req),
        .r0_wen          (r0_wen),
        .r0_strb         (r0_strb),
        .r0_wdata        (r0_wdata),
        .r0_addr         (r0_addr),
        .r0_gnt          (r0_gnt),
        .r0_recv         (r0_recv),
        .r0_ack          (r0_ack),
        .r0_error        (r0_error),
        .r0_rdata        (r0_rdata),
        .r1_req          (r1_req),
        .r1_wen          (r1_wen),
        .r1_strb         (r1_strb),
        .r1_wdata        (r1_wdata),
        .r1_addr         (r1_addr),
        .r1_gnt          (r1_gnt),
        .r1_recv         (r1_recv),
        .r1_ack          (r1_ack),
        .r1_error        (r1_error),
        .r1_rdata        (r1_rdata),
        .dmem_req        (dmem_req),
        .dmem_wen        (dmem_wen),
        .dmem_strb       (dmem_strb),
        .dmem_wdata      (dmem_wdata),
        .dmem_addr       (dmem_addr),
        .dmem_gnt        (dmem_gnt),
        .dmem_recv       (dmem_recv),
        .dmem_ack        (dmem_ack),
        .dmem_error      (dmem_error),
        .dmem_rdata      (dmem_rdata),
        .arb_outstanding (arb_outstanding),
        .arb_spurious    (arb_spurious)
    );

    always #5 g_clk = ~g_clk;

    int n_pass = 0;
    int n_chk  = 0;
    int n_fail = 0;

    // reference model state
    int q[$];
    bit lk_v;
    bit lk_id;
    int stv;
    bit spur;

    // model expectations for the current cycle
    bit          sv, sid;
    logic        e_req, e_wen, e_g0, e_g1, e_ack;
    logic        e_rc0, e_rc1, e_er0, e_er1;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata, e_addr;
    bit          last_g0, last_g1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        lk_v  = 0;
        lk_id = 0;
        stv   = 0;
        spur  = 0;
    endtask

    task automatic model_comb();
        bit full;
        full = (q.size() == MAX_OUT);
        sv   = 0;
        sid  = 0;
        if (!full) begin
            if (lk_v) begin
                sv = 1; sid = lk_id;
            end else if (r1_req && stv == STARVE_LIM) begin
                sv = 1; sid = 1;
            end else if (r0_req) begin
                sv = 1; sid = 0;
            end else if (r1_req) begin
                sv = 1; sid = 1;
            end
        end
        e_req   = sv && (sid ? r1_req : r0_req);
        e_wen   = sv ? (sid ? r1_wen : r0_wen) : 1'b0;
        e_strb  = sv ? (sid ? r1_strb : r0_strb) : 4'h0;
        e_wdata = sv ? (sid ? r1_wdata : r0_wdata) : 32'h0;
        e_addr  = sv ? (sid ? r1_addr : r0_addr) : 32'h0;
        e_g0    = dmem_gnt && e_req && !sid;
        e_g1    = dmem_gnt && e_req && sid;
        e_rc0 = 0; e_rc1 = 0; e_er0 = 0; e_er1 = 0;
        if (q.size() > 0) begin
            if (q[0] == 1) begin
                e_rc1 = dmem_recv; e_er1 = dmem_error; e_ack = r1_ack;
            end else begin
                e_rc0 = dmem_recv; e_er0 = dmem_error; e_ack = r0_ack;
            end
        end else begin
            e_ack = dmem_recv;
        end
    endtask

    task automatic model_seq();
        bit was_empty;
        was_empty = (q.size() == 0);
        if (!was_empty && dmem_recv && e_ack) void'(q.pop_front());
        if (e_req && dmem_gnt) q.push_back(int'(sid));
        if (e_req && !dmem_gnt) begin
            lk_v = 1; lk_id = sid;
        end else begin
            lk_v = 0;
        end
        if (e_g1) stv = 0;
        else if (r1_req && stv < STARVE_LIM) stv++;
        if (dmem_recv && was_empty) spur = 1;
        last_g0 = e_g0;
        last_g1 = e_g1;
    endtask

    task automatic check_all();
        chk("dmem_req",   dmem_req,   e_req);
        chk("dmem_wen",   dmem_wen,   e_wen);
        chk("dmem_strb",  dmem_strb,  e_strb);
        chk("dmem_wdata", dmem_wdata, e_wdata);
        chk("dmem_addr",  dmem_addr,  e_addr);
        chk("r0_gnt",     r0_gnt,     e_g0);
        chk("r1_gnt",     r1_gnt,     e_g1);
        chk("r0_recv",    r0_recv,    e_rc0);
        chk("r1_recv",    r1_recv,    e_rc1);
        chk("r0_error",   r0_error,   e_er0);
        chk("r1_error",   r1_error,   e_er1);
        chk("r0_rdata",   r0_rdata,   dmem_rdata);
        chk("r1_rdata",   r1_rdata,   dmem_rdata);
        chk("dmem_ack",   dmem_ack,   e_ack);
        chk("outstanding", arb_outstanding, q.size());
        chk("spurious",   arb_spurious, spur);
    endtask

    task automatic step();
        #1;
        model_comb();
        check_all();
        @(posedge g_clk);
        model_seq();
        @(negedge g_clk);
    endtask

    task automatic idle();
        r0_req = 0; r0_wen = 0; r0_strb = 0; r0_wdata = 0; r0_addr = 0;
        r1_req = 0; r1_wen = 0; r1_strb = 0; r1_wdata = 0; r1_addr = 0;
        r0_ack = 0; r1_ack = 0;
        dmem_gnt = 0; dmem_recv = 0; dmem_error = 0; dmem_rdata = 0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() > 0 && k < 8) begin
            idle();
            dmem_recv  = 1;
            dmem_rdata = 32'h0D0D_0000 + k;
            r0_ack = 1; r1_ack = 1;
            step();
            k++;
        end
        idle();
        #1 chk("drain_empty", arb_outstanding, 0);
    endtask

    task automatic pulse_reset();
        idle();
        #2 g_resetn = 0;
        model_reset();
        #1;
        model_comb();
        check_all();
        chk("rst_req", dmem_req, 0);
        chk("rst_spur", arb_spurious, 0);
        chk("rst_out", arb_outstanding, 0);
        @(negedge g_clk);
        g_resetn = 1;
    endtask

    initial begin
        idle();
        g_resetn = 0;
        model_reset();
        #1;
        model_comb();
        check_all();
        chk("reset_ack", dmem_ack, 0);
        @(negedge g_clk);
        g_resetn = 1;

        // both ports contend, bus grants every cycle
        r0_req = 1; r0_addr = 32'h0000_0100; r0_wdata = 32'h1111_0000;
        r0_wen = 1; r0_strb = 4'hF;
        r1_req = 1; r1_addr = 32'h8000_0200; r1_wdata = 32'h2222_0000;
        r1_wen = 0; r1_strb = 4'h3;
        dmem_gnt = 1; r0_ack = 1; r1_ack = 1;
        for (int i = 0; i < 6; i++) begin
            dmem_recv = (q.size() > 0);
            #1 chk("starve_r1_gnt", r1_gnt, (i == 4));
            chk("starve_r0_gnt", r0_gnt, (i < 4 || i == 5));
            step();
            if (last_g1) r1_req = 0;
        end
        drain();

        // r1 stalls on the bus, r0 arrives mid-stall
        r1_req = 1; r1_addr = 32'h1000_0010; r1_wdata = 32'hCAFE_0001;
        r1_wen = 1; r1_strb = 4'hF;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                r0_req = 1; r0_addr = 32'h2000_0000; r0_wdata = 32'h5;
            end
            #1 chk("lock_addr", dmem_addr, 32'h1000_0010);
            chk("lock_wdata", dmem_wdata, 32'hCAFE_0001);
            chk("lock_r0_gnt", r0_gnt, 0);
            step();
        end
        dmem_gnt = 1;
        #1 chk("lock_r1_gnt", r1_gnt, 1);
        step();
        r1_req = 0;
        #1 chk("after_lock_r0", r0_gnt, 1);
        step();
        drain();

        // fill the owner FIFO
        r0_req = 1; r0_addr = 32'h3000_0000; dmem_gnt = 1;
        step();
        step();
        #1 chk("full_req", dmem_req, 0);
        chk("full_out", arb_outstanding, 2);
        dmem_recv = 1; r0_ack = 1;
        step();
        dmem_recv = 0;
        #1 chk("refill_req", dmem_req, 1);
        step();
        drain();

        // interleaved r0,r1,r0 with in-order responses
        r0_req = 1; r0_addr = 32'h40; dmem_gnt = 1;
        step();
        r0_req = 0; r1_req = 1; r1_addr = 32'h44;
        step();
        r1_req = 0; r0_req = 1; r0_addr = 32'h48;
        dmem_recv = 1; dmem_rdata = 32'hA; r0_ack = 1; r1_ack = 1;
        #1 chk("il_r0_recv_a", r0_recv, 1);
        chk("il_r0_data_a", r0_rdata, 32'hA);
        chk("il_r1_recv_a", r1_recv, 0);
        step();
        dmem_rdata = 32'hB; dmem_error = 1;
        #1 chk("il_r1_recv_b", r1_recv, 1);
        chk("il_r1_err_b", r1_error, 1);
        chk("il_r0_err_b", r0_error, 0);
        chk("il_r0_gnt_c", r0_gnt, 1);
        step();
        r0_req = 0; dmem_rdata = 32'hC; dmem_error = 0;
        #1 chk("il_r0_recv_c", r0_recv, 1);
        chk("il_r0_data_c", r0_rdata, 32'hC);
        step();
        drain();

        // r1 withholds ack on its head response
        r1_req = 1; r1_addr = 32'h50; dmem_gnt = 1;
        step();
        idle();
        dmem_recv = 1; r0_ack = 1; r1_ack = 0; dmem_rdata = 32'h77;
        #1 chk("stall_ack", dmem_ack, 0);
        chk("stall_r0_recv", r0_recv, 0);
        chk("stall_r1_recv", r1_recv, 1);
        step();
        #1 chk("stall_out", arb_outstanding, 1);
        step();
        drain();

        // spurious response with empty FIFO
        dmem_recv = 1; dmem_rdata = 32'hDEAD;
        #1 chk("spur_ack", dmem_ack, 1);
        chk("spur_r0", r0_recv, 0);
        chk("spur_r1", r1_recv, 0);
        step();
        idle();
        #1 chk("spur_flag", arb_spurious, 1);
        step();
        pulse_reset();
        step();

        // randomized traffic with requesters honouring hold-until-gnt
        for (int i = 0; i < 400; i++) begin
            if (!r0_req && $urandom_range(0, 2) != 0) begin
                r0_req = 1; r0_wen = 1'($urandom);
                r0_strb = 4'($urandom); r0_wdata = $urandom;
                r0_addr = $urandom;
            end
            if (!r1_req && $urandom_range(0, 2) == 0) begin
                r1_req = 1; r1_wen = 1'($urandom);
                r1_strb = 4'($urandom); r1_wdata = $urandom;
                r1_addr = $urandom;
            end
            dmem_gnt   = ($urandom_range(0, 3) != 0);
            dmem_recv  = (q.size() > 0) ? 1'($urandom)
                                        : ($urandom_range(0, 60) == 0);
            dmem_error = 1'($urandom);
            dmem_rdata = $urandom;
            r0_ack     = ($urandom_range(0, 3) != 0);
            r1_ack     = ($urandom_range(0, 3) != 0);
            step();
            if (last_g0) r0_req = 0;
            if (last_g1) r1_req = 0;
        end

        // reset with ownership outstanding, later responses are spurious
        pulse_reset();
        dmem_recv = 1; dmem_rdata = 32'h1234;
        step();
        idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
